// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS pipeline stages.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/Adder32bits.sv
// 32-bit ripple-style adder with carry out; combinational, no backpressure.
module Adder32bits (
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] Sum_out,
  output logic        Carry_out
);

  assign {Carry_out, Sum_out} = {1'b0, A_in} + {1'b0, B_in};

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: 1-cycle request-to-IF/ID, stalls hold PC/IF/ID with a one-word skid.
// Optional perf counters (stall_cnt, flush_cnt) built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall_n,
  input  logic        bch_taken_ex,
  input  logic [31:0] bch_target_ex,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc_pls4_id,
  output logic        valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4;
  logic [31:0]  req_addr;
  logic [31:0]  skid, skid_nxt;
  logic [31:0]  instr_nxt, pls4_nxt;
  logic         valid_nxt;
  logic         pc_carry_unused;

  Adder32bits u_pc_adder (
    .A_in      (pc),
    .B_in      (32'h0000_0004),
    .Sum_out   (pc_plus4),
    .Carry_out (pc_carry_unused)
  );

  assign imem_req  = rst && (state == FETCH || state == DRAIN);
  assign imem_addr = req_addr;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    skid_nxt  = skid;
    instr_nxt = instr_id;
    pls4_nxt  = pc_pls4_id;
    valid_nxt = valid_id;
    if (bch_taken_ex) begin
      // Redirect wins over stall; an in-flight request must still be drained.
      pc_nxt    = {bch_target_ex[31:2], 2'b00};
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
      state_nxt = (state != HOLD && !imem_ready) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (pc_stall_n) begin
              instr_nxt = imem_rdata;
              pls4_nxt  = pc_plus4;
              valid_nxt = 1'b1;
              pc_nxt    = pc_plus4;
            end else begin
              skid_nxt  = imem_rdata;
              state_nxt = HOLD;
            end
          end else if (pc_stall_n) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (pc_stall_n) begin
            instr_nxt = skid;
            pls4_nxt  = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid       <= NOP_INSTR;
      instr_id   <= NOP_INSTR;
      pc_pls4_id <= 32'h0;
      valid_id   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      skid       <= skid_nxt;
      instr_id   <= instr_nxt;
      pc_pls4_id <= pls4_nxt;
      valid_id   <= valid_nxt;
      // Address only moves when a fresh request begins; DRAIN keeps the old one.
      if (state_nxt == FETCH) req_addr <= pc_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 16'h0;
    end else begin
      if ((!valid_id || !pc_stall_n) && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (bch_taken_ex && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
